rx_frame_buffer: RTL and testbench
==================================

# rx_frame_buffer

Receive-side frame buffer for the WimpFi node. It takes the byte stream that the Manchester receiver recovers and filters each frame on its destination address. Accepted payload bytes are held in a FIFO until the frame check passes, then handed to the host-side UART transmitter over a valid/ready handshake. It also raises the ACK-needed and ACK-received events for the transmit path, and keeps the receive error count.

## Interface

Parameters:
- DEPTH, 256: payload FIFO entries; power of two, at least 4.
- BCAST, 8'h2A: broadcast destination address ('*').

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset; asynchronous, active-low.
- mac, input, 8: this node's address.
- frame_start, input, 1: one-cycle pulse when the start-of-frame delimiter is detected.
- byte_valid, input, 1: one-cycle pulse; byte_data is valid.
- byte_data, input, 8: received byte.
- frame_end, input, 1: one-cycle pulse at end of frame, when the carrier drops.
- crc_ok, input, 1: frame check result; sampled only when frame_end is high.
- out_valid, output, 1: out_data holds a committed payload byte.
- out_data, output, 8: head of the FIFO.
- out_rdy, input, 1: the UART transmitter accepts a byte.
- ack_needed, output, 1: one-cycle pulse; an ACK must be sent to ack_addr.
- ack_received, output, 1: one-cycle pulse; an ACK addressed to mac arrived.
- ack_addr, output, 8: source address of the last accepted frame.
- rerrcnt, output, 8: receive error count; saturates at 8'hFF.

## Operation

- Frame layout in byte order: dest, src, type, payload..., with the frame check covered by crc_ok.
- FIFO pointers:
  - rd_ptr: read pointer.
  - wr_ptr: speculative write pointer.
  - cm_ptr: committed write pointer.
  - out_valid = (rd_ptr != cm_ptr).
- State machine:
  - IDLE: on frame_start, go to DEST and set wr_ptr = cm_ptr.
  - DEST: on a byte, set match = (byte == mac) or (byte == BCAST). Go to SRC if match, otherwise DROP.
  - SRC: on a byte, latch src and go to TYPE.
  - TYPE: on a byte, latch type and go to PAYLOAD.
  - PAYLOAD: write each byte at wr_ptr and increment wr_ptr. If the FIFO is full (wr_ptr+1 == rd_ptr modulo DEPTH), set ovf and go to DROP.
  - DROP: ignore bytes until frame_end.
- frame_end in any non-IDLE state returns the FSM to IDLE and evaluates the frame:
  - Frame is good when: state was PAYLOAD or TYPE-complete (at least 3 header bytes), match=1, ovf=0, and crc_ok=1.
  - Good frame: cm_ptr <= wr_ptr and ack_addr <= src.
    - If type == 8'h32 and dest == mac: pulse ack_needed.
    - If type == 8'h33 and dest == mac: pulse ack_received and discard the payload (cm_ptr unchanged).
    - Broadcast frames never generate ack_needed.
  - Bad frame with match=1 (crc fail, overflow, or fewer than 3 bytes): rerrcnt +1, saturating.
  - Bad frame with match=0: silent drop.
- frame_start outside IDLE (restart): discard the partial frame, set wr_ptr = cm_ptr, go to DEST. If match was 1, rerrcnt +1.
- Output handshake: a byte pops when out_valid && out_rdy, and rd_ptr increments. Pops may occur in any state.

## Timing

- Reset (rst=0, asynchronous): state IDLE, all pointers 0, out_valid=0, out_data=8'h00, ack_needed=0, ack_received=0, ack_addr=8'h00, rerrcnt=8'h00, match=0, ovf=0.
- out_data is registered:
  - It shows the FIFO entry at rd_ptr.
  - It updates the cycle after a pop or a commit.
  - Only one byte is visible at a time.
- Commit latency:
  - frame_end at cycle N gives cm_ptr updated and ack pulse at cycle N+1.
  - out_valid rises at N+1 when the FIFO was previously empty.
- Byte and end together: byte_valid and frame_end in the same cycle are processed as the byte first, then the end. frame_start has priority over byte_valid in the same cycle.
- Pop during commit: a pop and a commit in the same cycle are both applied.
- Full threshold: full uses the speculative wr_ptr, so DEPTH-1 bytes can be held. A payload that reaches full drops the entire frame.
- Wrap-around: pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- rerrcnt saturation: rerrcnt holds at 8'hFF.

## Test plan

1. Good unicast frame: mac=8'h41; frame 41,42,30,'H','i'; crc_ok=1. Required: out_data yields 'H' then 'i' under out_rdy=1. No ack pulse, rerrcnt=0, ack_addr=8'h42.
2. ACK-request type: frame 41,43,32,'x' with crc_ok=1. Required: ack_needed pulses once the cycle after frame_end, ack_addr=8'h43, and 'x' is delivered. The same frame sent to BCAST gives 'x' delivered with no ack_needed.
3. ACK frame: frame 41,43,33 with crc_ok=1. Required: ack_received pulses once, out_valid stays 0.
4. CRC failure plus filtering: frame 41,42,30,'a' with crc_ok=0. Required: nothing delivered, rerrcnt=1. Then frame 55,42,30,'a' with crc_ok=1: dropped, rerrcnt still 1.
5. Overflow and wrap: DEPTH=4 with out_rdy=0.
   - A 4-byte payload: frame dropped, rerrcnt +1, FIFO empty.
   - Then a 3-byte payload: committed.
   - Drain, and repeat 5 times: data stays intact across pointer wrap.
6. Reset and restart:
   - frame_start in the middle of a payload: partial frame discarded, the following frame delivered intact.
   - rst=0 asserted mid-frame: all outputs return to their reset values immediately.

Source files
------------

// File: rtl/rx_frame_buffer_if.sv
// Bundle of the receive byte stream, the host-side output handshake and the
// ACK/error status lines of rx_frame_buffer.
interface rx_frame_buffer_if;
  logic [7:0] mac;
  logic       frame_start;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_end;
  logic       crc_ok;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_rdy;
  logic       ack_needed;
  logic       ack_received;
  logic [7:0] ack_addr;
  logic [7:0] rerrcnt;

  // Driver of the byte stream and consumer of the payload bytes.
  modport master (
    output mac, frame_start, byte_valid, byte_data, frame_end, crc_ok, out_rdy,
    input  out_valid, out_data, ack_needed, ack_received, ack_addr, rerrcnt
  );

  // The frame buffer itself.
  modport slave (
    input  mac, frame_start, byte_valid, byte_data, frame_end, crc_ok, out_rdy,
    output out_valid, out_data, ack_needed, ack_received, ack_addr, rerrcnt
  );
endinterface

// File: rtl/rx_frame_buffer.sv
// Receive frame buffer: filters frames on destination address, stages the
// payload speculatively in a FIFO and commits it only when the frame check
// passes. Raises ACK events and counts receive errors.
module rx_frame_buffer #(
  parameter int         DEPTH = 256,
  parameter logic [7:0] BCAST = 8'h2A
) (
  input logic             clk,
  input logic             rst,
  rx_frame_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, DEST, SRC, TYPE, PAYLOAD, DROP} state_t;

  state_t          state_reg, state_next, state_byte;
  logic [AW-1:0]   rd_ptr_reg, wr_ptr_reg, cm_ptr_reg, rd_next;
  logic            match_reg, ovf_reg, dest_mac_reg;
  logic            match_byte, ovf_byte, dest_mac_byte;
  logic [7:0]      src_reg, type_reg, type_byte;
  logic [7:0]      out_data_reg, ack_addr_reg, rerrcnt_reg;
  logic            ack_needed_reg, ack_received_reg;
  logic            byte_take, full, wr_en, out_valid, pop;
  logic            frame_good, commit, ack_n_set, ack_r_set, err_inc;
  logic [7:0]      mem [DEPTH];

  // frame_start wins over a byte in the same cycle, so such a byte is dropped.
  assign byte_take = bus.byte_valid && !bus.frame_start;
  // Full is judged on the speculative pointer: one slot always stays free.
  assign full      = (wr_ptr_reg + AW'(1)) == rd_ptr_reg;
  assign out_valid = rd_ptr_reg != cm_ptr_reg;
  assign pop       = out_valid && bus.out_rdy;
  assign rd_next   = pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Next state: advance on the byte first, then let frame_start/frame_end override.
  always_comb begin
    state_byte    = state_reg;
    match_byte    = match_reg;
    ovf_byte      = ovf_reg;
    dest_mac_byte = dest_mac_reg;
    type_byte     = type_reg;
    if (byte_take) begin
      case (state_reg)
        DEST: begin
          match_byte    = (bus.byte_data == bus.mac) || (bus.byte_data == BCAST);
          dest_mac_byte = bus.byte_data == bus.mac;
          state_byte    = match_byte ? SRC : DROP;
        end
        SRC:  state_byte = TYPE;
        TYPE: begin
          type_byte  = bus.byte_data;
          state_byte = PAYLOAD;
        end
        PAYLOAD: begin
          if (full) begin
            ovf_byte   = 1'b1;
            state_byte = DROP;
          end
        end
        default: ;
      endcase
    end
    state_next = state_byte;
    if (bus.frame_start)                            state_next = DEST;
    else if (bus.frame_end && state_reg != IDLE)    state_next = IDLE;
  end

  // Outputs of the FSM: FIFO write, frame verdict, ACK strobes and error bump.
  always_comb begin
    wr_en      = byte_take && (state_reg == PAYLOAD) && !full;
    frame_good = 1'b0;
    commit     = 1'b0;
    ack_n_set  = 1'b0;
    ack_r_set  = 1'b0;
    err_inc    = 1'b0;
    if (bus.frame_start) begin
      err_inc = (state_reg != IDLE) && match_reg;
    end else if (bus.frame_end && state_reg != IDLE) begin
      frame_good = (state_byte == PAYLOAD) && match_byte && !ovf_byte && bus.crc_ok;
      if (frame_good) begin
        ack_r_set = (type_byte == 8'h33) && dest_mac_byte;
        ack_n_set = (type_byte == 8'h32) && dest_mac_byte;
        commit    = !ack_r_set;
      end else begin
        err_inc = match_byte;
      end
    end
  end

  // Payload storage; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= bus.byte_data;
  end

  // Pointers, frame context, registered head byte and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_reg       <= '0;
      wr_ptr_reg       <= '0;
      cm_ptr_reg       <= '0;
      match_reg        <= 1'b0;
      ovf_reg          <= 1'b0;
      dest_mac_reg     <= 1'b0;
      src_reg          <= 8'h00;
      type_reg         <= 8'h00;
      out_data_reg     <= 8'h00;
      ack_addr_reg     <= 8'h00;
      rerrcnt_reg      <= 8'h00;
      ack_needed_reg   <= 1'b0;
      ack_received_reg <= 1'b0;
    end else begin
      ack_needed_reg   <= ack_n_set;
      ack_received_reg <= ack_r_set;
      if (pop) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (bus.frame_start) begin
        wr_ptr_reg   <= cm_ptr_reg;
        match_reg    <= 1'b0;
        ovf_reg      <= 1'b0;
        dest_mac_reg <= 1'b0;
      end else begin
        match_reg    <= match_byte;
        ovf_reg      <= ovf_byte;
        dest_mac_reg <= dest_mac_byte;
        type_reg     <= type_byte;
        if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (byte_take && state_reg == SRC) src_reg <= bus.byte_data;
      end
      // A byte written in the same cycle as the end is part of the commit.
      if (commit) cm_ptr_reg <= wr_en ? wr_ptr_reg + AW'(1) : wr_ptr_reg;
      if (frame_good) ack_addr_reg <= src_reg;
      if (err_inc && rerrcnt_reg != 8'hFF) rerrcnt_reg <= rerrcnt_reg + 8'd1;
      // Write-first bypass keeps the head byte correct when the slot is written now.
      out_data_reg <= (wr_en && wr_ptr_reg == rd_next) ? bus.byte_data : mem[rd_next];
    end
  end

  assign bus.out_valid    = out_valid;
  assign bus.out_data     = out_data_reg;
  assign bus.ack_needed   = ack_needed_reg;
  assign bus.ack_received = ack_received_reg;
  assign bus.ack_addr     = ack_addr_reg;
  assign bus.rerrcnt      = rerrcnt_reg;
endmodule

// File: tb/tb_rx_frame_buffer.sv
// Bench for rx_frame_buffer: directed scenarios plus random frames checked
// every cycle against a frame-level reference model.
module tb_rx_frame_buffer;
  localparam int DEPTH = 4;
  localparam logic [7:0] BCAST = 8'h2A;
  localparam logic [7:0] MAC = 8'h41;

  logic clk = 1'b0;
  logic rst = 1'b0;
  rx_frame_buffer_if bus();

  rx_frame_buffer #(.DEPTH(DEPTH), .BCAST(BCAST)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int nframes = 0;
  int rdy_mode = 1;  // 0 never ready, 1 always ready, 2 random

  // Reference model state
  logic [7:0] q[$];        // committed, not yet delivered payload bytes
  logic [7:0] cur[$];      // bytes of the frame in progress
  bit         in_frame = 0;
  bit         m_ovf = 0;
  bit         exp_ackn = 0;
  bit         exp_ackr = 0;
  logic [7:0] exp_addr = 8'h00;
  logic [7:0] exp_err = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_match(input logic [7:0] d);
    return (d == MAC) || (d == BCAST);
  endfunction

  function automatic void bump_err();
    if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
  endfunction

  // Frame-level rules applied for the coming clock edge.
  task automatic model_apply(input bit fs, input bit bv, input logic [7:0] bd,
                             input bit fe, input bit crc);
    bit m;
    bit good;
    if (fs) begin
      if (in_frame && cur.size() >= 1 && is_match(cur[0])) bump_err();
      cur.delete();
      m_ovf = 0;
      in_frame = 1;
    end else if (in_frame) begin
      if (bv && !m_ovf) begin
        if (cur.size() >= 3 && is_match(cur[0]) &&
            (q.size() + cur.size() - 3) >= DEPTH - 1)
          m_ovf = 1;
        else
          cur.push_back(bd);
      end
      if (fe) begin
        m = cur.size() >= 1 && is_match(cur[0]);
        good = cur.size() >= 3 && m && !m_ovf && crc;
        if (good) begin
          exp_addr = cur[1];
          if (cur[2] == 8'h33 && cur[0] == MAC) exp_ackr = 1;
          else begin
            for (int i = 3; i < cur.size(); i++) q.push_back(cur[i]);
            if (cur[2] == 8'h32 && cur[0] == MAC) exp_ackn = 1;
          end
        end else if (m) begin
          bump_err();
        end
        in_frame = 0;
        cur.delete();
      end
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", bus.out_valid, q.size() != 0);
    if (q.size() != 0) chk("out_data", bus.out_data, q[0]);
    chk("ack_needed", bus.ack_needed, exp_ackn);
    chk("ack_received", bus.ack_received, exp_ackr);
    chk("rerrcnt", bus.rerrcnt, exp_err);
    chk("ack_addr", bus.ack_addr, exp_addr);
    exp_ackn = 0;
    exp_ackr = 0;
  endtask

  // One clock cycle: check what the last edge produced, drive, model, advance.
  task automatic step(input bit fs, input bit bv, input logic [7:0] bd,
                      input bit fe, input bit crc);
    bit rdy;
    bit pop_now;
    check_outputs();
    case (rdy_mode)
      0:       rdy = 0;
      1:       rdy = 1;
      default: rdy = 1'($urandom_range(0, 1));
    endcase
    bus.frame_start = fs;
    bus.byte_valid  = bv;
    bus.byte_data   = bd;
    bus.frame_end   = fe;
    bus.crc_ok      = crc;
    bus.out_rdy     = rdy;
    pop_now = rdy && (q.size() != 0);
    model_apply(fs, bv, bd, fe, crc);
    if (pop_now) void'(q.pop_front());
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, 1'($urandom_range(0, 1)));
  endtask

  task automatic send(input logic [7:0] fr[$], input bit crc, input bit do_end);
    bit merge;
    merge = do_end && fr.size() > 0 && ($urandom_range(0, 1) == 1);
    nframes++;
    $display("[TB] frame %0d: len=%0d dest=%02h crc=%0b end=%0b merged=%0b",
             nframes, fr.size(), (fr.size() > 0) ? fr[0] : 8'h00, crc, do_end, merge);
    step(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < fr.size(); i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      if (merge && i == fr.size() - 1) step(0, 1, fr[i], 1, crc);
      else step(0, 1, fr[i], 0, 1'($urandom_range(0, 1)));
    end
    if (do_end && !merge) step(0, 0, 8'h00, 1, crc);
    idle($urandom_range(0, 2));
  endtask

  task automatic drain();
    int save;
    save = rdy_mode;
    rdy_mode = 1;
    idle(DEPTH + 3);
    rdy_mode = save;
  endtask

  initial begin
    logic [7:0] fr[$];
    bus.mac = MAC;
    bus.frame_start = 0; bus.byte_valid = 0; bus.byte_data = 0;
    bus.frame_end = 0; bus.crc_ok = 0; bus.out_rdy = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_ack_needed", bus.ack_needed, 0);
    chk("rst_ack_received", bus.ack_received, 0);
    chk("rst_ack_addr", bus.ack_addr, 0);
    chk("rst_rerrcnt", bus.rerrcnt, 0);
    rst = 1;
    idle(2);

    // 1: good unicast frame
    rdy_mode = 1;
    fr = '{8'h41, 8'h42, 8'h30, 8'h48, 8'h69}; send(fr, 1, 1); drain();
    // 2: ACK request, unicast then broadcast
    fr = '{8'h41, 8'h43, 8'h32, 8'h78}; send(fr, 1, 1); drain();
    fr = '{BCAST, 8'h43, 8'h32, 8'h78}; send(fr, 1, 1); drain();
    // 3: ACK frame
    fr = '{8'h41, 8'h43, 8'h33}; send(fr, 1, 1); drain();
    // 4: CRC failure, then foreign destination
    fr = '{8'h41, 8'h42, 8'h30, 8'h61}; send(fr, 0, 1); drain();
    fr = '{8'h55, 8'h42, 8'h30, 8'h61}; send(fr, 1, 1); drain();
    // 5: overflow and pointer wrap with the consumer stalled
    rdy_mode = 0;
    fr = '{8'h41, 8'h42, 8'h30, 8'h01, 8'h02, 8'h03, 8'h04}; send(fr, 1, 1);
    for (int r = 0; r < 5; r++) begin
      rdy_mode = 0;
      fr = '{8'h41, 8'h42, 8'h30, 8'(8'h10 + r), 8'(8'h20 + r), 8'(8'h30 + r)};
      send(fr, 1, 1);
      drain();
    end
    // 6a: restart in the middle of a payload
    rdy_mode = 2;
    fr = '{8'h41, 8'h44, 8'h30, 8'h70, 8'h71}; send(fr, 1, 0);
    fr = '{8'h41, 8'h45, 8'h30, 8'h72, 8'h73}; send(fr, 1, 1);
    drain();

    // Random frames
    for (int n = 0; n < 60; n++) begin
      logic [7:0] dsel[3];
      logic [7:0] tsel[3];
      int plen;
      dsel = '{MAC, BCAST, 8'h55};
      tsel = '{8'h30, 8'h32, 8'h33};
      rdy_mode = 2;
      fr.delete();
      fr.push_back(dsel[$urandom_range(0, 2)]);
      fr.push_back(8'($urandom_range(0, 255)));
      fr.push_back(tsel[$urandom_range(0, 2)]);
      plen = $urandom_range(0, 4);
      for (int k = 0; k < plen; k++) fr.push_back(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 7) == 0) begin
        int keep;
        keep = $urandom_range(0, 2);
        while (fr.size() > keep) void'(fr.pop_back());
      end
      send(fr, $urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0);
    end
    drain();

    // 6b: asynchronous reset in the middle of a frame
    rdy_mode = 0;
    fr = '{8'h41, 8'h46, 8'h30, 8'h55}; send(fr, 1, 1);
    step(1, 0, 8'h00, 0, 0);
    step(0, 1, 8'h41, 0, 0);
    step(0, 1, 8'h47, 0, 0);
    #2 rst = 0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_out_data", bus.out_data, 0);
    chk("arst_ack_needed", bus.ack_needed, 0);
    chk("arst_ack_received", bus.ack_received, 0);
    chk("arst_ack_addr", bus.ack_addr, 0);
    chk("arst_rerrcnt", bus.rerrcnt, 0);
    q.delete(); cur.delete();
    in_frame = 0; m_ovf = 0; exp_ackn = 0; exp_ackr = 0;
    exp_addr = 8'h00; exp_err = 8'h00;
    bus.frame_start = 0; bus.byte_valid = 0; bus.frame_end = 0;
    @(negedge clk);
    rst = 1;
    idle(1);
    rdy_mode = 1;
    fr = '{8'h41, 8'h48, 8'h30, 8'hA5, 8'h5A}; send(fr, 1, 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
